// File: rtl/wisc_multicycle_ctrl.sv
// wisc_multicycle_ctrl
// Multi-cycle sequencer for the 16-bit WISC ISA. It owns the PC, the IR,
// the A/B operand latches, the result latch R, the effective-address latch
// and the NZV flag register. One shared memory port carries instruction and
// data traffic through a variable-latency req/ready handshake. The register
// file and the ALU are external and combinational.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   mem_req/we/addr/wdata      shared memory request (held until mem_ready)
//   mem_rdata, mem_ready       memory read data and request completion
//   rf_src1/src2, rf_rdata1/2  register file read addresses and data
//   rf_dst/we/wdata            register file write port
//   alu_op/a/b                 ALU command and operands
//   alu_result, alu_nzv        ALU result and flags {N,Z,V}
//   pc                         current program counter
//   hlt                        high while halted
//   retire                     one-cycle pulse per completed instruction
//
// state  | meaning
// FETCH  | read instruction at pc, pc += 2 on ready
// DECODE | read register operands into A/B; HLT goes to HALT
// EXEC   | ALU/immediate/PCS into R, address calc, branch resolution
// MEM    | data load/store at latched address
// WB     | write R into rf[IR[11:8]]
// HALT   | idle until reset

module wisc_multicycle_ctrl #(
    parameter int          AW         = 16,
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [2:0]  FLAG_RESET = 3'b000
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_ready,
    output logic [3:0]    rf_src1,
    output logic [3:0]    rf_src2,
    output logic [3:0]    rf_dst,
    output logic          rf_we,
    output logic [15:0]   rf_wdata,
    input  logic [15:0]   rf_rdata1,
    input  logic [15:0]   rf_rdata2,
    output logic [3:0]    alu_op,
    output logic [15:0]   alu_a,
    output logic [15:0]   alu_b,
    input  logic [15:0]   alu_result,
    input  logic [2:0]    alu_nzv,
    output logic [AW-1:0] pc,
    output logic          hlt,
    output logic          retire
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} stateT;

    stateT         state, stateNext;
    logic [AW-1:0] pcReg, pcNext;
    logic [AW-1:0] addrReg, addrNext;
    logic [15:0]   ir, irNext;
    logic [15:0]   opA, opANext;
    logic [15:0]   opB, opBNext;
    logic [15:0]   res, resNext;
    logic [2:0]    flags, flagsNext;
    // Holds mem_req low during the first cycle out of reset even though
    // the state register already sits in FETCH.
    logic          started;

    logic [3:0]    opcode;
    logic          flagN, flagZ, flagV;
    logic          condTrue;
    logic [15:0]   brOffset;
    logic [15:0]   memOffset;

    assign opcode    = ir[15:12];
    assign flagN     = flags[2];
    assign flagZ     = flags[1];
    assign flagV     = flags[0];
    assign brOffset  = {{6{ir[8]}}, ir[8:0], 1'b0};
    assign memOffset = {{11{ir[3]}}, ir[3:0], 1'b0};
    assign pc        = pcReg;

    always_comb begin
        case (ir[11:9])
            3'b000:  condTrue = ~flagZ;
            3'b001:  condTrue = flagZ;
            3'b010:  condTrue = ~flagZ & ~flagN;
            3'b011:  condTrue = flagN;
            3'b100:  condTrue = flagZ | (~flagZ & ~flagN);
            3'b101:  condTrue = flagN | flagZ;
            3'b110:  condTrue = flagV;
            default: condTrue = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            started <= 1'b0;
            pcReg   <= RESET_PC[AW-1:0];
            flags   <= FLAG_RESET;
            ir      <= '0;
            opA     <= '0;
            opB     <= '0;
            res     <= '0;
            addrReg <= '0;
        end else begin
            state   <= stateNext;
            started <= 1'b1;
            pcReg   <= pcNext;
            flags   <= flagsNext;
            ir      <= irNext;
            opA     <= opANext;
            opB     <= opBNext;
            res     <= resNext;
            addrReg <= addrNext;
        end
    end

    always_comb begin
        stateNext = state;
        pcNext    = pcReg;
        flagsNext = flags;
        irNext    = ir;
        opANext   = opA;
        opBNext   = opB;
        resNext   = res;
        addrNext  = addrReg;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rf_src1   = '0;
        rf_src2   = '0;
        rf_dst    = '0;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        alu_op    = '0;
        alu_a     = '0;
        alu_b     = '0;
        hlt       = 1'b0;
        retire    = 1'b0;

        case (state)
            FETCH: begin
                if (started) begin
                    mem_req  = 1'b1;
                    mem_addr = pcReg;
                    if (mem_ready) begin
                        irNext    = mem_rdata;
                        pcNext    = pcReg + AW'(2);
                        stateNext = DECODE;
                    end
                end
            end

            DECODE: begin
                rf_src1 = ir[7:4];
                // SW stores, and LLB/LHB merge into, the destination register.
                if (opcode == OP_SW || opcode == OP_LLB || opcode == OP_LHB)
                    rf_src2 = ir[11:8];
                else
                    rf_src2 = ir[3:0];
                opANext   = rf_rdata1;
                opBNext   = rf_rdata2;
                stateNext = (opcode == OP_HLT) ? HALT : EXEC;
            end

            EXEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB,
                    OP_SLL, OP_SRA, OP_ROR: begin
                        alu_op = opcode;
                        alu_a  = opA;
                        if (opcode == OP_SLL || opcode == OP_SRA || opcode == OP_ROR)
                            alu_b = {12'h000, ir[3:0]};
                        else
                            alu_b = opB;
                        resNext   = alu_result;
                        stateNext = WB;
                        if (opcode == OP_ADD || opcode == OP_SUB)
                            flagsNext = alu_nzv;
                        else if (opcode != OP_RED && opcode != OP_PADDSB)
                            flagsNext[1] = alu_nzv[1];
                    end
                    OP_LW, OP_SW: begin
                        alu_op    = OP_ADD;
                        alu_a     = opA;
                        alu_b     = memOffset;
                        addrNext  = alu_result[AW-1:0];
                        stateNext = MEM;
                    end
                    OP_LLB: begin
                        resNext   = (opB & 16'hFF00) | {8'h00, ir[7:0]};
                        stateNext = WB;
                    end
                    OP_LHB: begin
                        resNext   = (opB & 16'h00FF) | {ir[7:0], 8'h00};
                        stateNext = WB;
                    end
                    OP_PCS: begin
                        resNext   = 16'(pcReg);
                        stateNext = WB;
                    end
                    OP_B: begin
                        if (condTrue)
                            pcNext = pcReg + brOffset[AW-1:0];
                        retire    = 1'b1;
                        stateNext = FETCH;
                    end
                    OP_BR: begin
                        if (condTrue)
                            pcNext = opA[AW-1:0];
                        retire    = 1'b1;
                        stateNext = FETCH;
                    end
                    default: stateNext = HALT;
                endcase
            end

            MEM: begin
                mem_req   = 1'b1;
                mem_addr  = addrReg;
                mem_we    = (opcode == OP_SW);
                mem_wdata = opB;
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire    = 1'b1;
                        stateNext = FETCH;
                    end else begin
                        resNext   = mem_rdata;
                        stateNext = WB;
                    end
                end
            end

            WB: begin
                rf_we     = 1'b1;
                rf_dst    = ir[11:8];
                rf_wdata  = res;
                retire    = 1'b1;
                stateNext = FETCH;
            end

            HALT: begin
                hlt = 1'b1;
            end

            default: stateNext = FETCH;
        endcase
    end

endmodule

// File: tb/tb_wisc_multicycle_ctrl.sv
module tb_wisc_multicycle_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mem_req, mem_we, mem_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  rf_src1, rf_src2, rf_dst, alu_op;
    logic        rf_we, hlt, retire;
    logic [15:0] rf_wdata, rf_rdata1, rf_rdata2, alu_a, alu_b, alu_result;
    logic [2:0]  alu_nzv;
    logic [15:0] pc;

    wisc_multicycle_ctrl #(.AW(16), .RESET_PC(16'h0000), .FLAG_RESET(3'b000)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_dst(rf_dst), .rf_we(rf_we),
        .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .alu_nzv(alu_nzv), .pc(pc), .hlt(hlt), .retire(retire)
    );

    // Narrow-address instance: starts at 0xFE to exercise pc wrap.
    logic        rst8_n;
    logic        mem_req8, mem_we8, rf_we8, hlt8, retire8;
    logic [7:0]  mem_addr8, pc8;
    logic [15:0] mem_wdata8, mem_rdata8, rf_wdata8, alu_a8, alu_b8;
    logic [3:0]  rf_src1_8, rf_src2_8, rf_dst8, alu_op8;

    assign mem_rdata8 = (mem_addr8 == 8'hFE) ? 16'hE200 : 16'hF000;

    wisc_multicycle_ctrl #(.AW(8), .RESET_PC(16'h00FE), .FLAG_RESET(3'b000)) dut8 (
        .clk(clk), .rst_n(rst8_n),
        .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
        .mem_rdata(mem_rdata8), .mem_ready(mem_req8),
        .rf_src1(rf_src1_8), .rf_src2(rf_src2_8), .rf_dst(rf_dst8), .rf_we(rf_we8),
        .rf_wdata(rf_wdata8), .rf_rdata1(16'h0000), .rf_rdata2(16'h0000),
        .alu_op(alu_op8), .alu_a(alu_a8), .alu_b(alu_b8), .alu_result(16'h0000),
        .alu_nzv(3'b000), .pc(pc8), .hlt(hlt8), .retire(retire8)
    );

    int errors = 0;
    int checks = 0;

    // External ALU behaviour (environment, shared by DUT and reference model).
    function automatic logic [18:0] aluFn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [31:0] rr;
        logic        v;
        v = 1'b0;
        case (op)
            4'h0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            4'h1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            4'h2: r = a ^ b;
            4'h3: r = {8'h00, a[15:8] + a[7:0]};
            4'h4: r = a << b[3:0];
            4'h5: r = $signed(a) >>> b[3:0];
            4'h6: begin rr = {a, a} >> b[3:0]; r = rr[15:0]; end
            4'h7: r = {a[15:8] + b[15:8], a[7:0] + b[7:0]};
            default: r = a + b;
        endcase
        return {r[15], (r == 16'h0000), v, r};
    endfunction

    // Environment: memory, register file, ALU.
    logic [15:0] mem [0:255];
    logic [15:0] rf  [0:15];
    logic [15:0] mMem [0:255];
    logic [15:0] mRegs [0:15];
    logic [2:0]  mFlags;
    logic [15:0] mPc;
    logic        loadReq;
    int          waitCycles, waitCnt, rndWait;
    bit          randWait;

    assign mem_rdata = mem[mem_addr[8:1]];
    assign rf_rdata1 = rf[rf_src1];
    assign rf_rdata2 = rf[rf_src2];
    assign {alu_nzv, alu_result} = aluFn(alu_op, alu_a, alu_b);
    assign mem_ready = mem_req && (waitCnt >= (randWait ? rndWait : waitCycles));

    always @(posedge clk) begin
        if (!rst_n || !mem_req) waitCnt <= 0;
        else if (mem_ready) begin
            waitCnt <= 0;
            rndWait <= $urandom_range(0, 2);
            if (mem_we) mem[mem_addr[8:1]] <= mem_wdata;
        end else waitCnt <= waitCnt + 1;
        if (rf_we) rf[rf_dst] <= rf_wdata;
        if (loadReq) begin
            for (int i = 0; i < 256; i++) mem[i] <= mMem[i];
            for (int i = 0; i < 16; i++) rf[i] <= mRegs[i];
        end
    end

    typedef struct {
        bit          wr, st, br, halt, isMem;
        logic [3:0]  dst;
        logic [15:0] val, addr, data, nextPc;
        int          lat;
    } eff_t;

    function automatic bit condModel(input logic [2:0] cc, input logic [2:0] f);
        bit n, z, v;
        n = f[2]; z = f[1]; v = f[0];
        case (cc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // ISA-level reference: executes one instruction on the architectural state.
    task automatic modelStep(output eff_t e);
        logic [15:0] ins, pc2, ea;
        logic [18:0] ar;
        logic [3:0]  op, rd, rs, rt;
        ins = mMem[mPc[8:1]];
        op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
        pc2 = mPc + 16'd2;
        ea = mRegs[rs] + {{11{rt[3]}}, rt, 1'b0};
        e = '{default: 0};
        e.nextPc = pc2;
        e.lat = 4;
        e.dst = rd;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h4, 4'h5, 4'h6: begin
                if (op >= 4'h4 && op <= 4'h6) ar = aluFn(op, mRegs[rs], {12'h000, rt});
                else ar = aluFn(op, mRegs[rs], mRegs[rt]);
                e.wr = 1; e.val = ar[15:0];
                if (op <= 4'h1) mFlags = ar[18:16];
                else if (op != 4'h3 && op != 4'h7) mFlags[1] = ar[17];
            end
            4'h8: begin e.wr = 1; e.isMem = 1; e.lat = 5; e.val = mMem[ea[8:1]]; end
            4'h9: begin e.st = 1; e.isMem = 1; e.addr = ea; e.data = mRegs[rd]; mMem[ea[8:1]] = mRegs[rd]; end
            4'hA: begin e.wr = 1; e.val = {mRegs[rd][15:8], ins[7:0]}; end
            4'hB: begin e.wr = 1; e.val = {ins[7:0], mRegs[rd][7:0]}; end
            4'hC: begin e.br = 1; if (condModel(ins[11:9], mFlags)) e.nextPc = pc2 + {{6{ins[8]}}, ins[8:0], 1'b0}; end
            4'hD: begin e.br = 1; if (condModel(ins[11:9], mFlags)) e.nextPc = mRegs[rs]; end
            4'hE: begin e.wr = 1; e.val = pc2; end
            default: e.halt = 1;
        endcase
        if (e.wr) mRegs[rd] = e.val;
        mPc = e.nextPc;
    endtask

    task automatic clearProg();
        for (int i = 0; i < 256; i++) mMem[i] = 16'hF000;
        for (int i = 0; i < 16; i++) mRegs[i] = 16'h0000;
        mFlags = 3'b000;
        mPc = 16'h0000;
    endtask

    task automatic put(input logic [15:0] addr, input logic [15:0] ins);
        mMem[addr[8:1]] = ins;
    endtask

    // Ends at the negedge of the first FETCH cycle that drives mem_req.
    task automatic startProgram();
        rst_n = 1'b0; loadReq = 1'b1;
        @(posedge clk); @(negedge clk);
        loadReq = 1'b0; rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Entered at the negedge of cycle 1 of the next instruction.
    task automatic runProgram(input int maxInstr, input bit chkLat, input int fWait, input int mWait);
        eff_t e;
        int cyc, expLat;
        for (int k = 0; k < maxInstr; k++) begin
            modelStep(e);
            cyc = 1;
            if (e.halt) begin
                while (!hlt && cyc < 200) begin @(negedge clk); cyc++; end
                checks++;
                if (hlt !== 1'b1) begin errors++; $display("FAIL halt_timeout: hlt=%b required 1", hlt); return; end
                if (chkLat) begin
                    checks++;
                    if (cyc !== 3 + fWait) begin errors++; $display("FAIL hlt_latency: got %0d required %0d", cyc, 3 + fWait); end
                end
                checks++;
                if (pc !== e.nextPc) begin errors++; $display("FAIL halt_pc: got %h required %h", pc, e.nextPc); end
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    checks++;
                    if (mem_req !== 1'b0 || retire !== 1'b0 || hlt !== 1'b1 || pc !== e.nextPc) begin
                        errors++;
                        $display("FAIL halt_idle: req=%b retire=%b hlt=%b pc=%h required 0 0 1 %h", mem_req, retire, hlt, pc, e.nextPc);
                    end
                end
                return;
            end
            while (!retire && cyc < 200) begin @(negedge clk); cyc++; end
            checks++;
            if (retire !== 1'b1) begin errors++; $display("FAIL retire_timeout: instr %0d retire=%b required 1", k, retire); return; end
            checks++;
            if (rf_we !== e.wr) begin errors++; $display("FAIL rf_we: got %b required %b", rf_we, e.wr); end
            if (e.wr) begin
                checks++;
                if (rf_dst !== e.dst || rf_wdata !== e.val) begin
                    errors++;
                    $display("FAIL rf_write: got R%0d=%h required R%0d=%h", rf_dst, rf_wdata, e.dst, e.val);
                end
            end
            if (e.st) begin
                checks++;
                if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL store: got req=%b we=%b addr=%h data=%h required 1 1 %h %h",
                             mem_req, mem_we, mem_addr, mem_wdata, e.addr, e.data);
                end
            end
            if (e.br) begin
                checks++;
                if (mem_req !== 1'b0) begin errors++; $display("FAIL branch_req: got %b required 0", mem_req); end
            end
            if (chkLat && !e.br) begin
                expLat = e.lat + fWait + (e.isMem ? mWait : 0);
                checks++;
                if (cyc !== expLat) begin errors++; $display("FAIL latency: got %0d required %0d", cyc, expLat); end
            end
            @(negedge clk);
            checks++;
            if (pc !== e.nextPc) begin errors++; $display("FAIL pc: got %h required %h", pc, e.nextPc); end
        end
    endtask

    task automatic test_reset();
        clearProg();
        rst_n = 1'b0; loadReq = 1'b1;
        @(posedge clk); @(negedge clk);
        loadReq = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || rf_we !== 1'b0 || retire !== 1'b0 || hlt !== 1'b0 ||
            pc !== 16'h0000 || mem_addr !== 16'h0000 || alu_op !== 4'h0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b we=%b retire=%b hlt=%b pc=%h addr=%h required all zero",
                     mem_req, rf_we, retire, hlt, pc, mem_addr);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL req_before_clock: got %b required 0", mem_req); end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL first_fetch: req=%b we=%b addr=%h required 1 0 0000", mem_req, mem_we, mem_addr);
        end
        runProgram(1, 1'b1, 0, 0);
    endtask

    task automatic test_llb_lhb();
        clearProg();
        put(16'h0000, 16'hA134);
        put(16'h0002, 16'hB112);
        startProgram();
        runProgram(3, 1'b1, 0, 0);
        checks++;
        if (rf[1] !== 16'h1234) begin errors++; $display("FAIL llb_lhb_r1: got %h required 1234", rf[1]); end
    endtask

    task automatic test_alu_flags();
        clearProg();
        mRegs[1] = 16'h7FFF;
        mRegs[2] = 16'h0001;
        put(16'h0000, 16'h0312);
        put(16'h0002, 16'h2433);
        put(16'h0004, 16'hC601);
        put(16'h0008, 16'hCC01);
        put(16'h000C, 16'hC201);
        put(16'h0010, 16'hC001);
        startProgram();
        runProgram(10, 1'b1, 0, 0);
        checks++;
        if (rf[3] !== 16'h8000 || rf[4] !== 16'h0000) begin
            errors++; $display("FAIL add_xor: got R3=%h R4=%h required 8000 0000", rf[3], rf[4]);
        end
        checks++;
        if (pc !== 16'h0014) begin errors++; $display("FAIL flag_branches_pc: got %h required 0014", pc); end
    endtask

    task automatic test_mem();
        clearProg();
        mRegs[0] = 16'h0010;
        mRegs[3] = 16'h8000;
        put(16'h0000, 16'h930F);
        put(16'h0002, 16'h850F);
        waitCycles = 3;
        startProgram();
        runProgram(3, 1'b1, 3, 3);
        waitCycles = 0;
        checks++;
        if (rf[5] !== 16'h8000 || mem[7] !== 16'h8000) begin
            errors++; $display("FAIL sw_lw: got R5=%h mem[000E]=%h required 8000 8000", rf[5], mem[7]);
        end
    endtask

    task automatic test_branch();
        clearProg();
        put(16'h0000, 16'hA620);
        put(16'h0002, 16'h2777);
        put(16'h0004, 16'hDE60);
        put(16'h001E, 16'h2767);
        put(16'h0020, 16'hC3FE);
        put(16'h0022, 16'hA600);
        put(16'h0024, 16'hB601);
        put(16'h0026, 16'hDE60);
        startProgram();
        runProgram(20, 1'b1, 0, 0);
        checks++;
        if (pc !== 16'h0102) begin errors++; $display("FAIL br_target: got %h required 0102", pc); end
    endtask

    task automatic test_halt_reset();
        clearProg();
        put(16'h0000, 16'hA640);
        put(16'h0002, 16'hDE60);
        startProgram();
        runProgram(5, 1'b1, 0, 0);
        clearProg();
        put(16'h0000, 16'hA655);
        startProgram();
        runProgram(1, 1'b1, 0, 0);
        waitCycles = 5;
        #2;
        checks++;
        if (mem_req !== 1'b1 || pc !== 16'h0002) begin
            errors++; $display("FAIL stalled_fetch: req=%b pc=%h required 1 0002", mem_req, pc);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || pc !== 16'h0000) begin
            errors++; $display("FAIL reset_mid_fetch: req=%b pc=%h required 0 0000", mem_req, pc);
        end
        waitCycles = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0] op, rd, rs, rt;
        logic [15:0] ins;
        for (int it = 0; it < 4; it++) begin
            clearProg();
            for (int i = 1; i < 16; i++) mRegs[i] = 16'($urandom);
            mRegs[0] = 16'h0180;
            for (int i = 0; i < 48; i++) begin
                rd = 4'($urandom_range(1, 15));
                rs = 4'($urandom);
                rt = 4'($urandom);
                case ($urandom_range(0, 5))
                    0: begin op = 4'($urandom_range(0, 7)); ins = {op, rd, rs, rt}; end
                    1: ins = {($urandom_range(0, 1) == 0) ? 4'hA : 4'hB, rd, 8'($urandom)};
                    2: ins = {4'hE, rd, 8'h00};
                    3: ins = {4'h8, rd, 4'h0, rt};
                    4: ins = {4'h9, rs, 4'h0, rt};
                    default: ins = {4'hC, 3'($urandom), 9'($urandom_range(1, 3))};
                endcase
                mMem[i] = ins;
            end
            randWait = 1'b1;
            startProgram();
            runProgram(60, 1'b0, 0, 0);
            randWait = 1'b0;
        end
    endtask

    task automatic test_aw8();
        rst8_n = 1'b0;
        @(negedge clk);
        rst8_n = 1'b1;
        checks++;
        if (pc8 !== 8'hFE || mem_req8 !== 1'b0) begin
            errors++; $display("FAIL aw8_reset: pc=%h req=%b required FE 0", pc8, mem_req8);
        end
        @(negedge clk);
        checks++;
        if (mem_req8 !== 1'b1 || mem_addr8 !== 8'hFE) begin
            errors++; $display("FAIL aw8_fetch: req=%b addr=%h required 1 FE", mem_req8, mem_addr8);
        end
        @(negedge clk);
        checks++;
        if (pc8 !== 8'h00) begin errors++; $display("FAIL aw8_wrap: got %h required 00", pc8); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (retire8 !== 1'b1 || rf_we8 !== 1'b1 || rf_dst8 !== 4'd2 || rf_wdata8 !== 16'h0000) begin
            errors++;
            $display("FAIL aw8_pcs: retire=%b we=%b dst=%0d data=%h required 1 1 2 0000", retire8, rf_we8, rf_dst8, rf_wdata8);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (hlt8 !== 1'b1 || pc8 !== 8'h02) begin
            errors++; $display("FAIL aw8_halt: hlt=%b pc=%h required 1 02", hlt8, pc8);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rst8_n = 1'b0;
        loadReq = 1'b0;
        waitCycles = 0;
        randWait = 1'b0;
        @(negedge clk);
        test_reset();
        test_llb_lhb();
        test_alu_flags();
        test_mem();
        test_branch();
        test_halt_reset();
        test_random();
        test_aw8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
